// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state and owner encodings for the memory arbiter
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Counter width that can hold 0..max, never narrower than one bit.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/starve_cnt.sv
// rtl/starve_cnt.sv - saturating count of data grants taken while a fetch waits
module starve_cnt
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] MAXV = CW'(STARVE_MAX);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAXV) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt == MAXV);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one combinational-read memory
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = 3,
  parameter int IDX_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic [31:0]      if_rdata,
  output logic             if_ready,
  input  logic             d_rd,
  input  logic             d_wr,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic [31:0]      d_rdata,
  output logic             d_ready,
  output logic [IDX_W-1:0] m_idx,
  output logic [31:0]      m_wdata,
  output logic             m_we,
  input  logic [31:0]      m_rdata,
  output logic             busy
);

  state_t state, next_state;
  owner_t owner;
  logic   wr_flag;
  logic   d_req, grant, fetch_win, sat;
  logic   unused_addr_hi;

  assign d_req     = d_rd | d_wr;
  assign grant     = (state == IDLE) && (if_req || d_req);
  // Fetch only wins a contended cycle once the data port has used up its allowance.
  assign fetch_win = if_req && (!d_req || sat);

  assign unused_addr_hi = ^{if_addr[31:IDX_W], d_addr[31:IDX_W]};

  starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (grant && !fetch_win && if_req),
    .clr (grant && fetch_win),
    .sat (sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (if_req || d_req) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    m_we     = 1'b0;
    busy     = 1'b0;
    if_ready = 1'b0;
    d_ready  = 1'b0;
    case (state)
      ACCESS: begin
        busy = 1'b1;
        m_we = wr_flag;
      end
      RESP: begin
        busy     = 1'b1;
        if_ready = (owner == OWN_IF);
        d_ready  = (owner == OWN_D);
      end
      default: ;
    endcase
  end

  // A simultaneous read+write on the data port is taken as a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= OWN_IF;
      wr_flag <= 1'b0;
      m_idx   <= '0;
      m_wdata <= '0;
    end else if (grant) begin
      if (fetch_win) begin
        owner   <= OWN_IF;
        wr_flag <= 1'b0;
        m_idx   <= if_addr[IDX_W-1:0];
      end else begin
        owner   <= OWN_D;
        wr_flag <= d_wr;
        m_idx   <= d_addr[IDX_W-1:0];
        m_wdata <= d_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (state == ACCESS && !wr_flag) begin
      if (owner == OWN_IF) begin
        if_rdata <= m_rdata;
      end else begin
        d_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector and sequence bench for mem_arbiter
module tb_mem_arbiter;

  localparam int IDX_W = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_req, d_rd, d_wr;
  logic [31:0]      if_addr, d_addr, d_wdata;
  logic [31:0]      if_rdata, d_rdata, m_wdata, m_rdata;
  logic             if_ready, d_ready, m_we, busy;
  logic [IDX_W-1:0] m_idx;

  logic [31:0] mem [0:(1<<IDX_W)-1];
  int          wr_cnt = 0;
  int          total = 0;
  int          bad = 0;

  mem_arbiter #(.STARVE_MAX(3), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_idx(m_idx), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign m_rdata = mem[m_idx];

  always @(posedge clk) begin
    if (m_we) begin
      mem[m_idx] <= m_wdata;
      wr_cnt     <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] exp_idx;
    logic        exp_we;
    logic        exp_if_ready;
    logic        exp_d_ready;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drop_reqs();
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
  endtask

  // Holds if_req and d_rd continuously and checks the order of grants (1 = data).
  task automatic contention(input string tag, input logic [7:0] exp_order, input int n);
    logic seen;
    if_req = 1'b1; if_addr = 32'd3; d_rd = 1'b1; d_addr = 32'd900;
    for (int g = 0; g < n; g++) begin
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (if_ready || d_ready) seen = 1'b1;
      end
      if (!seen) chk($sformatf("%s_grant%0d_timeout", tag, g), 32'hff, {31'd0, exp_order[g]});
      else chk($sformatf("%s_grant%0d", tag, g), {31'd0, d_ready}, {31'd0, exp_order[g]});
    end
    drop_reqs();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drop_reqs();
    if_addr = '0; d_addr = '0; d_wdata = '0;

    vecs[0] = '{1'b0, 32'd0, 1'b0, 1'b1, 32'd3, 32'h8C250000, 32'd3, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 32'd3, 1'b0, 1'b0, 32'd0, 32'h0, 32'd3, 1'b0, 1'b1, 1'b0, 32'h8C250000, 32'h0};
    vecs[2] = '{1'b0, 32'd0, 1'b0, 1'b1, 32'd900, 32'hA5A5, 32'd900, 1'b1, 1'b0, 1'b1, 32'h8C250000, 32'h0};
    vecs[3] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd900, 32'h0, 32'd900, 1'b0, 1'b0, 1'b1, 32'h8C250000, 32'hA5A5};
    vecs[4] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 32'h1234, 32'd5, 1'b1, 1'b0, 1'b1, 32'h8C250000, 32'hA5A5};
    vecs[5] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 32'h0, 32'd5, 1'b0, 1'b0, 1'b1, 32'h8C250000, 32'h1234};
    vecs[6] = '{1'b1, 32'd3, 1'b1, 1'b0, 32'd900, 32'h0, 32'd900, 1'b0, 1'b0, 1'b1, 32'h8C250000, 32'hA5A5};
    vecs[7] = '{1'b1, 32'h1005, 1'b0, 1'b0, 32'd0, 32'h0, 32'd5, 1'b0, 1'b1, 1'b0, 32'h1234, 32'hA5A5};

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_m_we", {31'd0, m_we}, 32'd0);
    chk("rst_m_idx", {20'd0, m_idx}, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_readies", {30'd0, if_ready, d_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_rd = vecs[i].d_rd; d_wr = vecs[i].d_wr;
      d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      @(negedge clk);
      chk($sformatf("v%0d_m_idx", i), {20'd0, m_idx}, vecs[i].exp_idx);
      chk($sformatf("v%0d_m_we", i), {31'd0, m_we}, {31'd0, vecs[i].exp_we});
      chk($sformatf("v%0d_busy_acc", i), {31'd0, busy}, 32'd1);
      if (vecs[i].exp_we) chk($sformatf("v%0d_m_wdata", i), m_wdata, vecs[i].d_wdata);
      @(negedge clk);
      chk($sformatf("v%0d_if_ready", i), {31'd0, if_ready}, {31'd0, vecs[i].exp_if_ready});
      chk($sformatf("v%0d_d_ready", i), {31'd0, d_ready}, {31'd0, vecs[i].exp_d_ready});
      chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].exp_if_rdata);
      chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].exp_d_rdata);
      chk($sformatf("v%0d_m_we_resp", i), {31'd0, m_we}, 32'd0);
      drop_reqs();
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), {29'd0, busy, if_ready, d_ready}, 32'd0);
    end

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_m_idx", c), {20'd0, m_idx}, 32'd5);
      chk($sformatf("hold%0d_busy_we", c), {30'd0, busy, m_we}, 32'd0);
    end

    contention("cont1", 8'b0111_0111, 8);

    // Reset lands in the ACCESS cycle of a write granted while a fetch waits.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'd3;
    d_wr = 1'b1; d_addr = 32'd7; d_wdata = 32'hDEAD;
    begin
      int wr_before;
      wr_before = wr_cnt;
      @(negedge clk);
      chk("rstacc_m_we_before", {31'd0, m_we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rstacc_m_we", {31'd0, m_we}, 32'd0);
      chk("rstacc_busy", {31'd0, busy}, 32'd0);
      chk("rstacc_m_idx", {20'd0, m_idx}, 32'd0);
      chk("rstacc_d_rdata", d_rdata, 32'd0);
      chk("rstacc_if_rdata", if_rdata, 32'd0);
      drop_reqs();
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("rstacc_no_ready%0d", c), {30'd0, if_ready, d_ready}, 32'd0);
      end
      chk("rstacc_no_write", wr_cnt, wr_before);
    end

    contention("cont2", 8'b0000_0111, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, meaning consecutive data-port grants allowed while a fetch waits.
REQ-002 SHALL have parameter IDX_W, default 12, meaning memory word-index width.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port if_req  input  1  fetch read request, held until if_ready.
REQ-006 SHALL have port if_addr  input  32  fetch word address.
REQ-007 SHALL have port if_rdata  output  32  fetched instruction word.
REQ-008 SHALL have port if_ready  output  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port d_rd, d_wr  input  1 each  data read/write requests, held until d_ready.
REQ-010 SHALL have port d_addr  input  32  data word address; d_wdata input 32 write data.
REQ-011 SHALL have port d_rdata  output  32  data read word; d_ready output 1 one-cycle completion pulse.
REQ-012 SHALL have ports m_idx output IDX_W, m_wdata output 32, m_we output 1, m_rdata input 32 (combinational-read memory).
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; ACCESS and RESP last exactly one cycle each.
REQ-015 In IDLE with no request, SHALL remain IDLE with all memory-side outputs held.
REQ-016 In IDLE with a request, SHALL select an owner, latch owner, address[IDX_W-1:0], write flag and write data at the clock edge, and enter ACCESS.
REQ-017 Priority: data port wins over fetch, except when starvation counter equals STARVE_MAX and if_req is high, in which case fetch wins.
REQ-018 d_rd and d_wr both high SHALL be treated as a write; read is ignored.
REQ-019 In ACCESS, m_idx/m_wdata SHALL present latched values; m_we SHALL be high only in ACCESS for a write grant.
REQ-020 At ACCESS->RESP edge, SHALL register m_rdata into owner's rdata (reads only; writes leave rdata unchanged).
REQ-021 In RESP, SHALL pulse owner's ready for exactly one cycle; non-owner ready stays 0.
REQ-022 Requests present during ACCESS or RESP SHALL be ignored; arbitration occurs only in IDLE.
REQ-023 Latency: request high in cycle t (IDLE) -> memory access cycle t+1 -> ready/rdata valid cycle t+2; throughput one access per 3 cycles.
REQ-024 Starvation counter: increments (saturating at STARVE_MAX) on a data grant while if_req high; clears on any fetch grant; unchanged on data grant with if_req low.
REQ-025 rdata outputs SHALL hold their last value until next read completion for that port.

Reset
REQ-026 On rst high, asynchronously: state IDLE, counter 0, if_ready 0, d_ready 0, if_rdata 0, d_rdata 0, m_idx 0, m_wdata 0, m_we 0, busy 0.
REQ-027 Reset in ACCESS SHALL abort the access immediately (m_we drops with rst); no ready pulse follows.
REQ-028 After rst deassertion, first arbitration SHALL occur at first rising edge with state IDLE.

Structure
REQ-029 State encoding (IDLE, ACCESS, RESP) and owner encoding (OWN_IF, OWN_D) SHALL live in shared package mem_pkg.
REQ-030 Starvation counter SHALL be a separate sub-module starve_cnt (inc, clr, sat output).
REQ-031 Memory SHALL remain external; arbiter contains no storage array.

Verification
REQ-032 Fetch only: if_req, if_addr=3, mem[3]=32'h8C250000 -> m_idx=3 in t+1, if_ready=1, if_rdata=32'h8C250000 in t+2.
REQ-033 Write then read: d_wr addr=900 data=32'hA5A5 -> m_we=1 one cycle; then d_rd addr=900 -> d_rdata=32'hA5A5.
REQ-034 Contention: if_req and d_rd held continuously, STARVE_MAX=3 -> grant order D,D,D,IF,D,D,D,IF.
REQ-035 d_rd and d_wr both high, addr 5 -> write performed, d_ready once, d_rdata unchanged.
REQ-036 rst asserted during ACCESS of a write -> m_we 0 immediately, no d_ready, state IDLE, counter 0.
